// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD block family.
//   GcdWidth  default operand width in bits
//   CntWidth  width of the feeder's issue/drop statistics counters
//   feeder_state_e  operand feeder FSM states
package gcd_pkg;

    localparam int unsigned GcdWidth = 8;
    localparam int unsigned CntWidth = 16;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } feeder_state_e;

endpackage

// File: rtl/gcd_operand_feeder_if.sv
// Producer/core handshake bundle seen by the operand feeder.
//   wr_valid/wr_ready/wr_a/wr_b       producer write channel
//   input_available                   core is in READY
//   operand_A/operand_B/input_ready   operands and start pulse to the core
// master: producer + core side; slave: the feeder.
interface gcd_operand_feeder_if #(
    parameter int unsigned width = gcd_pkg::GcdWidth
);
    logic             wr_valid;
    logic             wr_ready;
    logic [width-1:0] wr_a;
    logic [width-1:0] wr_b;
    logic             input_available;
    logic [width-1:0] operand_A;
    logic [width-1:0] operand_B;
    logic             input_ready;

    modport master (
        output wr_valid, wr_a, wr_b, input_available,
        input  wr_ready, operand_A, operand_B, input_ready
    );

    modport slave (
        input  wr_valid, wr_a, wr_b, input_available,
        output wr_ready, operand_A, operand_B, input_ready
    );
endinterface

// File: rtl/gcd_pair_fifo.sv
// Synchronous FIFO of {a, b} operand pairs.
//   clk, rst_n        clock, asynchronous active-low reset (clears pointers/count)
//   push, push_a/b    write a pair (ignored when full)
//   pop               drop the head pair (ignored when empty)
//   head_a/head_b     current head pair
//   count/full/empty  occupancy
// depth must be a power of two so the pointers wrap naturally.
module gcd_pair_fifo
    import gcd_pkg::*;
#(
    parameter int unsigned width = GcdWidth,
    parameter int unsigned depth = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [width-1:0]        push_a,
    input  logic [width-1:0]        push_b,
    input  logic                    pop,
    output logic [width-1:0]        head_a,
    output logic [width-1:0]        head_b,
    output logic [$clog2(depth):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int unsigned PtrWidth = $clog2(depth);
    localparam logic [PtrWidth:0] CountFull = (PtrWidth + 1)'(depth);

    logic [2*width-1:0]  mem [depth];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrWidth:0]   count_q;
    logic                do_push, do_pop;

    assign full    = (count_q == CountFull);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrWidth + 1)'(1);
                2'b01:   count_q <= count_q - (PtrWidth + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= {push_a, push_b};
    end

    assign {head_a, head_b} = mem[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/gcd_operand_feeder.sv
// Operand stage in front of the GCD core: buffers producer pairs and issues them
// one at a time through the core's input_available/input_ready handshake.
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   bus                 slave side of gcd_operand_feeder_if (producer + core)
//   fifo_count          pairs currently stored
//   issue_cnt           pairs issued (wraps)
//   drop_cnt            pairs discarded by the zero filter (wraps)
// Optional: define GCD_FEEDER_ZERO_SKIP_EN to discard pairs holding a zero
// operand, which would otherwise hang the subtractive core.
module gcd_operand_feeder
    import gcd_pkg::*;
#(
    parameter int unsigned width = GcdWidth,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    gcd_operand_feeder_if.slave     bus,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [CntWidth-1:0]     issue_cnt,
    output logic [CntWidth-1:0]     drop_cnt
);
    feeder_state_e       state_q, state_d;
    logic                fifo_full, fifo_empty, fifo_pop;
    logic [width-1:0]    head_a, head_b;
    logic                head_zero;
    logic                load, drop, issue;
    logic [width-1:0]    operand_a_q, operand_b_q;
    logic                input_ready_q;
    logic [CntWidth-1:0] issue_cnt_q;

    gcd_pair_fifo #(
        .width (width),
        .depth (DEPTH)
    ) u_fifo (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .push   (bus.wr_valid),
        .push_a (bus.wr_a),
        .push_b (bus.wr_b),
        .pop    (fifo_pop),
        .head_a (head_a),
        .head_b (head_b),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // A pop in the same cycle does not open a slot while full.
    assign bus.wr_ready = !fifo_full;

`ifdef GCD_FEEDER_ZERO_SKIP_EN
    assign head_zero = (head_a == '0) || (head_b == '0);
`else
    assign head_zero = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= StIdle;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!fifo_empty && !head_zero && bus.input_available) state_d = StIssue;
            StIssue: state_d = StWait;
            // Wait for the core to leave READY so one availability window issues once.
            StWait:  if (!bus.input_available) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load  = 1'b0;
        drop  = 1'b0;
        issue = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    if (head_zero)                drop = 1'b1;
                    else if (bus.input_available) load = 1'b1;
                end
            end
            StIssue: issue = 1'b1;
            default: ;
        endcase
    end

    assign fifo_pop = load || drop;

    // input_ready is registered from the ISSUE state, so the pulse lags the
    // operand load by one cycle and operands are stable before it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            operand_a_q   <= '0;
            operand_b_q   <= '0;
            input_ready_q <= 1'b0;
            issue_cnt_q   <= '0;
        end else begin
            if (load) begin
                operand_a_q <= head_a;
                operand_b_q <= head_b;
            end
            input_ready_q <= issue;
            if (issue) issue_cnt_q <= issue_cnt_q + CntWidth'(1);
        end
    end

`ifdef GCD_FEEDER_ZERO_SKIP_EN
    logic [CntWidth-1:0] drop_cnt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  drop_cnt_q <= '0;
        else if (drop)   drop_cnt_q <= drop_cnt_q + CntWidth'(1);
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

    assign bus.operand_A   = operand_a_q;
    assign bus.operand_B   = operand_b_q;
    assign bus.input_ready = input_ready_q;
    assign issue_cnt       = issue_cnt_q;
endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Self-checking bench for gcd_operand_feeder: directed scenarios plus a
// randomized producer/core run scored against a FIFO-order reference queue.
module tb_gcd_operand_feeder;
    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic           sys_clk = 1'b0;
    logic           sys_rst_n = 1'b0;
    logic [2:0]     fifo_count;
    logic [15:0]    issue_cnt;
    logic [15:0]    drop_cnt;

    gcd_operand_feeder_if #(.width(W)) bus ();

    gcd_operand_feeder #(
        .width (W),
        .DEPTH (D)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .bus        (bus),
        .fifo_count (fifo_count),
        .issue_cnt  (issue_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_issues = 0;
    int exp_drops = 0;
    logic [2*W-1:0] model_q[$];

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.wr_valid = 1'b1;
        bus.wr_a = a;
        bus.wr_b = b;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic settle_idle();
        bus.input_available = 1'b0;
        bus.wr_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        logic [52:0] got, want;
        bus.wr_valid = 1'b0;
        bus.wr_a = '0;
        bus.wr_b = '0;
        bus.input_available = 1'b0;
        sys_rst_n = 1'b0;
        repeat (2) tick();
        got = {bus.operand_A, bus.operand_B, bus.input_ready, bus.wr_ready, fifo_count,
               issue_cnt, drop_cnt};
        want = {8'd0, 8'd0, 1'b0, 1'b1, 3'd0, 16'd0, 16'd0};
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h", got, want);
        end
        sys_rst_n = 1'b1;
        bus.input_available = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (bus.input_ready !== 1'b0 || fifo_count !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_idle_quiet: got rdy=%b cnt=%0d want rdy=0 cnt=0",
                         bus.input_ready, fifo_count);
            end
        end
        bus.input_available = 1'b0;
    endtask

    task automatic test_single_issue();
        settle_idle();
        bus.input_available = 1'b1;
        push_pair(8'd24, 8'd18);
        n_cmp++;
        if (fifo_count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_push_count: got %0d want 1", fifo_count);
        end
        tick();
        n_cmp++;
        if ({bus.operand_A, bus.operand_B, bus.input_ready} !== {8'd24, 8'd18, 1'b0}) begin
            n_fail++;
            $display("FAIL single_operands: got A=%0d B=%0d rdy=%b want A=24 B=18 rdy=0",
                     bus.operand_A, bus.operand_B, bus.input_ready);
        end
        tick();
        exp_issues++;
        n_cmp++;
        if (bus.input_ready !== 1'b1 || issue_cnt !== 16'(exp_issues)) begin
            n_fail++;
            $display("FAIL single_pulse: got rdy=%b cnt=%0d want rdy=1 cnt=%0d",
                     bus.input_ready, issue_cnt, exp_issues);
        end
        tick();
        n_cmp++;
        if (bus.input_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse_width: got rdy=%b want 0", bus.input_ready);
        end
    endtask

    task automatic test_no_double_issue();
        int pulses = 0;
        // Still in the post-issue window with input_available held high.
        push_pair(8'd105, 8'd99);
        for (int i = 0; i < 4; i++) begin
            if (bus.input_ready === 1'b1) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses != 0 || fifo_count !== 3'd1 || issue_cnt !== 16'(exp_issues)) begin
            n_fail++;
            $display("FAIL no_double_issue: got pulses=%0d cnt=%0d issues=%0d want 0/1/%0d",
                     pulses, fifo_count, issue_cnt, exp_issues);
        end
        bus.input_available = 1'b0;
        tick();
        bus.input_available = 1'b1;
        tick();
        n_cmp++;
        if ({bus.operand_A, bus.operand_B} !== {8'd105, 8'd99}) begin
            n_fail++;
            $display("FAIL second_operands: got A=%0d B=%0d want A=105 B=99",
                     bus.operand_A, bus.operand_B);
        end
        tick();
        exp_issues++;
        n_cmp++;
        if (bus.input_ready !== 1'b1 || issue_cnt !== 16'(exp_issues)) begin
            n_fail++;
            $display("FAIL second_pulse: got rdy=%b cnt=%0d want rdy=1 cnt=%0d",
                     bus.input_ready, issue_cnt, exp_issues);
        end
    endtask

    task automatic test_full_order();
        logic [W-1:0] a, b;
        logic [2*W-1:0] exp;
        int got_n = 0;
        int cyc = 0;
        settle_idle();
        model_q.delete();
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom_range(1, 255));
            b = W'($urandom_range(1, 255));
            if (i < int'(D)) model_q.push_back({a, b});
            push_pair(a, b);
        end
        n_cmp++;
        if (fifo_count !== 3'(D) || bus.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: got cnt=%0d wr_ready=%b want cnt=%0d wr_ready=0",
                     fifo_count, bus.wr_ready, D);
        end
        bus.input_available = 1'b1;
        while (got_n < int'(D) && cyc < 100) begin
            tick();
            cyc++;
            if (bus.input_ready === 1'b1) begin
                exp = model_q.pop_front();
                exp_issues++;
                got_n++;
                n_cmp++;
                if ({bus.operand_A, bus.operand_B} !== exp) begin
                    n_fail++;
                    $display("FAIL full_order_%0d: got %h want %h", got_n,
                             {bus.operand_A, bus.operand_B}, exp);
                end
                bus.input_available = 1'b0;
                tick();
                cyc++;
                bus.input_available = 1'b1;
            end
        end
        n_cmp++;
        if (got_n != int'(D) || fifo_count !== 3'd0 || issue_cnt !== 16'(exp_issues)) begin
            n_fail++;
            $display("FAIL full_drain: got issued=%0d cnt=%0d issues=%0d want %0d/0/%0d",
                     got_n, fifo_count, issue_cnt, D, exp_issues);
        end
    endtask

    task automatic test_zero_filter();
        logic [2*W-1:0] exp_seq[$];
        logic [2*W-1:0] exp;
        int cyc = 0;
        settle_idle();
        push_pair(8'd0, 8'd7);
        push_pair(8'd12, 8'd8);
`ifdef GCD_FEEDER_ZERO_SKIP_EN
        exp_drops++;
`else
        exp_seq.push_back({8'd0, 8'd7});
`endif
        exp_seq.push_back({8'd12, 8'd8});
        bus.input_available = 1'b1;
        while (exp_seq.size() != 0 && cyc < 100) begin
            tick();
            cyc++;
            if (bus.input_ready === 1'b1) begin
                exp = exp_seq.pop_front();
                exp_issues++;
                n_cmp++;
                if ({bus.operand_A, bus.operand_B} !== exp) begin
                    n_fail++;
                    $display("FAIL zero_filter_order: got %h want %h",
                             {bus.operand_A, bus.operand_B}, exp);
                end
                bus.input_available = 1'b0;
                tick();
                bus.input_available = 1'b1;
            end
        end
        repeat (4) tick();
        n_cmp++;
        if (exp_seq.size() != 0 || drop_cnt !== 16'(exp_drops) ||
            issue_cnt !== 16'(exp_issues) || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL zero_filter_counts: got left=%0d drop=%0d iss=%0d cnt=%0d want 0/%0d/%0d/0",
                     exp_seq.size(), drop_cnt, issue_cnt, fifo_count, exp_drops, exp_issues);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic [2*W-1:0] exp;
        int busy = 0;
        int last_pulse = -10;
        settle_idle();
        model_q.delete();
        bus.input_available = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (bus.input_ready === 1'b1) begin
                n_cmp++;
                if (cyc - last_pulse < 3) begin
                    n_fail++;
                    $display("FAIL random_spacing: got gap %0d want >= 3", cyc - last_pulse);
                end
                last_pulse = cyc;
                exp_issues++;
                n_cmp++;
                if (model_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL random_spurious: got %h want no issue",
                             {bus.operand_A, bus.operand_B});
                end else begin
                    exp = model_q.pop_front();
                    if ({bus.operand_A, bus.operand_B} !== exp) begin
                        n_fail++;
                        $display("FAIL random_order: got %h want %h",
                                 {bus.operand_A, bus.operand_B}, exp);
                    end
                end
                bus.input_available = 1'b0;
                busy = int'($urandom_range(1, 3));
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) bus.input_available = 1'b1;
            end
            bus.wr_valid = 1'b0;
            if (cyc < 200 && $urandom_range(0, 2) != 0) begin
                a = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
                b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
                bus.wr_valid = 1'b1;
                bus.wr_a = a;
                bus.wr_b = b;
                if (bus.wr_ready === 1'b1) begin
`ifdef GCD_FEEDER_ZERO_SKIP_EN
                    if (a == '0 || b == '0) exp_drops++;
                    else model_q.push_back({a, b});
`else
                    model_q.push_back({a, b});
`endif
                end
            end
            tick();
        end
        bus.wr_valid = 1'b0;
        n_cmp++;
        if (model_q.size() != 0 || fifo_count !== 3'd0 || issue_cnt !== 16'(exp_issues) ||
            drop_cnt !== 16'(exp_drops)) begin
            n_fail++;
            $display("FAIL random_final: got left=%0d cnt=%0d iss=%0d drop=%0d want 0/0/%0d/%0d",
                     model_q.size(), fifo_count, issue_cnt, drop_cnt, exp_issues, exp_drops);
        end
    endtask

    task automatic test_reset_mid_issue();
        int cyc = 0;
        int pulses = 0;
        settle_idle();
        push_pair(8'd9, 8'd6);
        push_pair(8'd15, 8'd10);
        bus.input_available = 1'b1;
        while (bus.input_ready !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (bus.input_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_reach_pulse: got rdy=%b want 1", bus.input_ready);
        end
        #3;
        sys_rst_n = 1'b0;
        #1;
        exp_issues = 0;
        exp_drops = 0;
        n_cmp++;
        if ({bus.input_ready, fifo_count, issue_cnt, bus.operand_A, bus.operand_B} !==
            {1'b0, 3'd0, 16'd0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_async: got rdy=%b cnt=%0d iss=%0d A=%0d B=%0d want all 0",
                     bus.input_ready, fifo_count, issue_cnt, bus.operand_A, bus.operand_B);
        end
        #2;
        sys_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.input_ready === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || fifo_count !== 3'd0 || issue_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid_after: got pulses=%0d cnt=%0d iss=%0d want 0/0/0",
                     pulses, fifo_count, issue_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_no_double_issue();
        test_full_order();
        test_zero_filter();
        test_random();
        test_reset_mid_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/gcd_operand_feeder.md
# gcd_operand_feeder

Upstream operand stage for the GCD core. Buffers operand pairs written by a producer in a small FIFO and presents them one at a time to the core through its `input_available` / `input_ready` handshake. The block sits directly in front of the core and drives its `operand_A`, `operand_B` and `input_ready` inputs.

## Interface
- `width`, 8: operand width in bits.
- `DEPTH`, 4: FIFO depth in pairs. Must be a power of two, ≥ 2.
- `sys_clk`  in  1  system clock; all state updates on the rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  producer offers a pair this cycle.
- `wr_ready`  out  1  FIFO can accept a pair.
- `wr_a`  in  width  operand A of the offered pair.
- `wr_b`  in  width  operand B of the offered pair.
- `input_available`  in  1  core is in READY and will accept operands.
- `operand_A`  out  width  registered operand A to the core.
- `operand_B`  out  width  registered operand B to the core.
- `input_ready`  out  1  one-cycle start pulse to the core.
- `fifo_count`  out  $clog2(DEPTH)+1  number of pairs currently stored.
- `issue_cnt`  out  16  pairs issued to the core; wraps modulo 2^16.
- `drop_cnt`  out  16  pairs discarded by the zero filter; wraps modulo 2^16.

## Operation
- Push: a pair is written when `wr_valid && wr_ready`. `wr_ready = (fifo_count < DEPTH)`.
  - When full, `wr_ready` is low even if a pop occurs in the same cycle; no push is accepted that cycle.
  - Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If `input_available` is high and the FIFO is not empty: pop the head, load it into `operand_A`/`operand_B`, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: drive `input_ready` high for exactly this cycle, increment `issue_cnt`, and go to WAIT.
- WAIT: stay until `input_available` is sampled low, then go to IDLE. This prevents a double issue while the core leaves READY.
- `operand_A`/`operand_B` hold their values until the next pop. They are stable at least one cycle before and throughout the `input_ready` pulse.
- FIFO order is strictly first-in, first-out.
- Simultaneous push and pop (not full): both take effect and `fifo_count` is unchanged.
- A push into an empty FIFO becomes eligible for a pop on the following cycle.

## Timing
- Reset values: `operand_A`=0, `operand_B`=0, `input_ready`=0, `wr_ready`=1, `fifo_count`=0, `issue_cnt`=0, `drop_cnt`=0. FSM resets to IDLE.
- Reset asserted mid-operation clears all state immediately (asynchronously), including any stored pairs. `input_ready` falls without waiting for a clock edge.
- Issue latency, with `input_available` high and a non-empty FIFO at edge k:
  - operands update at edge k;
  - `input_ready` rises at edge k+1 and falls at edge k+2.
- Minimum spacing between two issues is 3 cycles (IDLE→ISSUE→WAIT→IDLE).
- Push latency: a pair pushed at edge k is visible in `fifo_count` after edge k.
- All outputs are registered except `wr_ready`, which is decoded from the registered count.

## Configuration
- Macro: `GCD_FEEDER_ZERO_SKIP_EN`.
- Defined: in IDLE, a head pair with `wr_a==0` or `wr_b==0` is popped and discarded.
  - `drop_cnt` increments and `input_ready` is not pulsed.
  - Discards run one per cycle, independent of `input_available`.
  - This protects the subtractive core, which never terminates on a zero operand.
- Not defined: zero pairs are issued like any other pair, and `drop_cnt` is tied to 0.

## Structure
- Shared package `gcd_pkg` holds:
  - the default operand width constant;
  - the counter width constant (16);
  - the feeder FSM state typedef (IDLE, ISSUE, WAIT).
- One sub-module: `gcd_pair_fifo`. It is a parameterised synchronous FIFO of {a, b} pairs with push, pop, count, full and empty, using the same clock and reset.
- The FSM, operand registers and counters live in `gcd_operand_feeder`.

## Test plan
- Reset: hold `sys_rst_n`=0 → all outputs at their reset values, `wr_ready`=1. Release → no activity with the FIFO empty.
- Single issue: push (24,18), `input_available`=1 → next edge `operand_A`=24, `operand_B`=18; one edge later `input_ready`=1 for exactly one cycle; `issue_cnt`=1.
- No double issue: keep `input_available` high after the pulse with (105,99) queued → no second pulse. Drop it low for one cycle, then high → (105,99) issued, `issue_cnt`=2.
- Full/order: `input_available`=0, push 5 pairs with DEPTH=4 → `fifo_count`=4, `wr_ready`=0, 5th pair lost. Enable issuing with the core handshake emulated → pairs 1–4 issued in order, then `fifo_count`=0.
- Zero filter: push (0,7) then (12,8).
  - Macro defined → `drop_cnt`=1 and only (12,8) is issued.
  - Macro undefined → (0,7) is issued first and `drop_cnt`=0.
- Reset during ISSUE: assert `sys_rst_n` mid-cycle → `input_ready` drops immediately, `fifo_count`=0, and no issue follows release.
